// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg : shared constants and types for the pipeline hazard control
// Rev 1.0
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

  localparam logic [1:0]  TUSE_NONE        = 2'd3;
  localparam int          DEF_MULT_CYCLES  = 5;
  localparam int          DEF_DIV_CYCLES   = 10;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_4180;

  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_md_busy_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// md_busy_timer : tracks the mult/div occupancy window with a down-counter
// Rev 1.0
// ---------------------------------------------------------------------------
module md_busy_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  input  logic cancel,
  output logic busy
);

  localparam logic [3:0] c_mult_load = 4'(MULT_CYCLES);
  localparam logic [3:0] c_div_load  = 4'(DIV_CYCLES);

  md_state_t  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  // Loading N keeps busy high for exactly N cycles: the last busy cycle has cnt==1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          state_d = MD_BUSY;
          cnt_d   = is_div ? c_div_load : c_mult_load;
        end
      end
      MD_BUSY: begin
        if (cancel) begin
          state_d = MD_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = MD_IDLE;
          end
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == MD_BUSY);

  // The hazard unit stalls any MDU instruction while busy, so a second start cannot arrive.
  a_no_start_while_busy : assert property (
    @(posedge clk) disable iff (reset) !(start && state_q == MD_BUSY)
  );

endmodule : md_busy_timer
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl : stall/flush/redirect sequencer for the 5-stage pipeline.
// Option: define MDU_CANCEL_EN to abort a running mult/div on exception entry.
// Rev 1.0
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int          MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int          DIV_CYCLES  = DEF_DIV_CYCLES,
  parameter logic [31:0] EXC_VECTOR  = DEF_EXC_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  d_rs_addr,
  input  logic [4:0]  d_rt_addr,
  input  logic [1:0]  d_rs_tuse,
  input  logic [1:0]  d_rt_tuse,
  input  logic        d_is_md,
  input  logic [4:0]  e_wr_addr,
  input  logic [1:0]  e_tnew,
  input  logic [4:0]  m_wr_addr,
  input  logic [1:0]  m_tnew,
  input  logic        e_md_start,
  input  logic        e_md_is_div,
  input  logic        m_exc_valid,
  input  logic        m_is_eret,
  input  logic [31:0] epc,
  output logic        f_en,
  output logic        d_en,
  output logic        d_clr,
  output logic        e_clr,
  output logic        req,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc,
  output logic        md_busy
);

  logic stall_rs;
  logic stall_rt;
  logic md_stall;
  logic stall;
  logic md_start;
  logic md_cancel;

  // Register 0 is never a real producer, so a zero destination never creates a hazard.
  always_comb begin
    stall_rs = (d_rs_tuse != TUSE_NONE) &&
               (((d_rs_addr == e_wr_addr) && (e_wr_addr != 5'd0) && (d_rs_tuse < e_tnew)) ||
                ((d_rs_addr == m_wr_addr) && (m_wr_addr != 5'd0) && (d_rs_tuse < m_tnew)));
    stall_rt = (d_rt_tuse != TUSE_NONE) &&
               (((d_rt_addr == e_wr_addr) && (e_wr_addr != 5'd0) && (d_rt_tuse < e_tnew)) ||
                ((d_rt_addr == m_wr_addr) && (m_wr_addr != 5'd0) && (d_rt_tuse < m_tnew)));
    md_stall = d_is_md && (md_busy || e_md_start);
    stall    = stall_rs || stall_rt || md_stall;
  end

  // An MDU op in E is squashed by an exception taken in the same cycle.
  assign md_start = e_md_start && !req;

`ifdef MDU_CANCEL_EN
  assign md_cancel = req;
`else
  assign md_cancel = 1'b0;
`endif

  md_busy_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_timer (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start),
    .is_div (e_md_is_div),
    .cancel (md_cancel),
    .busy   (md_busy)
  );

  // Priority: reset > exception > eret > stall > idle.
  always_comb begin
    f_en        = 1'b1;
    d_en        = 1'b1;
    d_clr       = 1'b0;
    e_clr       = 1'b0;
    req         = 1'b0;
    pc_redirect = 1'b0;
    redirect_pc = EXC_VECTOR;
    if (reset) begin
      f_en = 1'b1;
    end else if (m_exc_valid) begin
      req         = 1'b1;
      pc_redirect = 1'b1;
    end else if (m_is_eret) begin
      pc_redirect = 1'b1;
      redirect_pc = epc;
      d_clr       = 1'b1;
      e_clr       = 1'b1;
    end else if (stall) begin
      f_en  = 1'b0;
      d_en  = 1'b0;
      e_clr = 1'b1;
    end
  end

endmodule : pipe_hazard_ctrl
`default_nettype wire
